// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Front-end sequencer for the 5-stage pipeline. It owns the pc write enable,
//   the IF/ID write enable and the IF/ID, ID/EX and EX/MEM flushes. It resolves
//   D-cache freezes, taken branches, jumps, load-use hazards and I-cache misses.
//
// Ports
//   clock, rst            rising-edge clock, synchronous active-high reset
//   icache_hit            fetch at the current pc hits this cycle
//   icache_ready          I-cache line fill complete (pulse)
//   dcache_busy           D-cache access in MEM not finished
//   ex_mem_pcsrc          branch taken, resolved in MEM
//   id_jump               jump decoded in ID
//   id_rs, id_rt          source registers of the instruction in ID
//   id_ex_memread         instruction in EX is a load
//   id_ex_rt              load destination register in EX
//   pc_we, if_id_we       write enables (Mealy, combinational)
//   if_id_flush,
//   id_ex_flush,
//   ex_mem_flush          per-stage bubble insertion (Mealy, combinational)
//   stall_cycles          registered, saturating count of cycles with pc_we=0
//   miss_error            registered, sticky: I-miss outlasted MISS_TIMEOUT
//   state                 registered FSM state: RUN=0, IMISS=1, DWAIT=2
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int REG_W        = 5,
  parameter int CNT_W        = 16,
  parameter int MISS_TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             icache_hit,
  input  logic             icache_ready,
  input  logic             dcache_busy,
  input  logic             ex_mem_pcsrc,
  input  logic             id_jump,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_ex_memread,
  input  logic [REG_W-1:0] id_ex_rt,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             miss_error,
  output logic [1:0]       state
);

  localparam int MISS_W = (MISS_TIMEOUT < 1) ? 1 : $clog2(MISS_TIMEOUT + 1);
  localparam logic [MISS_W-1:0] MISS_MAX  = MISS_W'(MISS_TIMEOUT);
  localparam logic [CNT_W-1:0]  STALL_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_IMISS = 2'd1,
    ST_DWAIT = 2'd2,
    ST_BAD   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;
  logic              miss_error_q, miss_error_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              load_use_s;

  // Load-use hazard: a load in EX writes a non-zero register read by ID.
  always_comb begin
    load_use_s = id_ex_memread && (id_ex_rt != {REG_W{1'b0}}) &&
                 ((id_ex_rt == id_rs) || (id_ex_rt == id_rt));
  end

  // Next-state and Mealy control outputs; first matching rule wins.
  always_comb begin
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    state_d      = state_q;
    miss_cnt_d   = miss_cnt_q;
    miss_error_d = miss_error_q;

    if (rst) begin
      // Everything downstream is bubbled while the pipe comes out of reset.
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      state_d      = ST_RUN;
      miss_cnt_d   = {MISS_W{1'b0}};
      miss_error_d = 1'b0;
    end else begin
      case (state_q)
        // DWAIT shares the RUN rules once the D-cache releases: EX/MEM was
        // frozen, so any branch it holds is re-presented now.
        ST_RUN, ST_DWAIT: begin
          if (dcache_busy) begin
            state_d = ST_DWAIT;
          end else if (ex_mem_pcsrc) begin
            pc_we        = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            state_d      = ST_RUN;
          end else if (id_jump) begin
            pc_we       = 1'b1;
            if_id_flush = 1'b1;
            state_d     = ST_RUN;
          end else if (load_use_s) begin
            id_ex_flush = 1'b1;
            state_d     = ST_RUN;
          end else if (!icache_hit) begin
            if_id_flush = 1'b1;
            miss_cnt_d  = {MISS_W{1'b0}};
            state_d     = ST_IMISS;
          end else begin
            pc_we    = 1'b1;
            if_id_we = 1'b1;
            state_d  = ST_RUN;
          end
        end
        // IF/ID holds a bubble here, so jump and load-use cannot apply.
        ST_IMISS: begin
          if (dcache_busy) begin
            state_d = ST_DWAIT;
          end else if (ex_mem_pcsrc) begin
            pc_we        = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            state_d      = ST_RUN;
          end else if (icache_ready) begin
            if_id_flush = 1'b1;
            state_d     = ST_RUN;
          end else begin
            if_id_flush = 1'b1;
            // Raise the error on the first cycle spent past the timeout.
            if (miss_cnt_q == MISS_MAX) begin
              miss_error_d = 1'b1;
            end else begin
              miss_cnt_d = miss_cnt_q + MISS_W'(1);
            end
          end
        end
        default: begin
          // Unused encoding: hold everything frozen and recover to RUN.
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the pc did not advance.
  always_comb begin
    if (rst) begin
      stall_d = {CNT_W{1'b0}};
    end else if (!pc_we && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + CNT_W'(1);
    end else begin
      stall_d = stall_q;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q      <= ST_RUN;
      miss_cnt_q   <= {MISS_W{1'b0}};
      miss_error_q <= 1'b0;
      stall_q      <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      miss_cnt_q   <= miss_cnt_d;
      miss_error_q <= miss_error_d;
      stall_q      <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
  assign miss_error   = miss_error_q;
  assign state        = state_q;

endmodule
